// File: rtl/conv_pkg.sv
// Shared definitions for the systolic convolution pipeline.
// The input sequencer and the result collector both use these capture constants.
package conv_pkg;

  // Result collector control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } conv_state_t;

  // Width of the array output and of each captured result.
  localparam int CONV_DATA_W     = 8;
  // Run-counter value at which C11 is final on the array output.
  localparam int CONV_FIRST_CAP  = 7;
  // Counter distance between successive finals (C12, C21, C22).
  localparam int CONV_CAP_STRIDE = 3;
  // Run-counter width; must hold CONV_FIRST_CAP + 3*CONV_CAP_STRIDE.
  localparam int CONV_CNT_W      = 5;
  // Number of results in one 2x2 output tile.
  localparam int CONV_NUM_RES    = 4;

endpackage

// File: rtl/conv_max4.sv
// Combinational unsigned maximum of four values.
// It is used as the 2x2 max-pool reduction of a result tile.
module conv_max4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y
);

  logic [W-1:0] max_ab;
  logic [W-1:0] max_cd;

  // Two-level compare tree: two pairwise maxima, then the larger of those two.
  always_comb begin
    max_ab = (a > b) ? a : b;
    max_cd = (c > d) ? c : d;
    y      = (max_ab > max_cd) ? max_ab : max_cd;
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects the four final 3x3 convolution results (C11, C12, C21, C22) from the
// systolic array's serial output. The results are captured at fixed counter
// offsets after start, then held for the consumer until a valid/ready handshake.
// Optional feature: define CONV_MAXPOOL_EN to add pool_out, which is the max of
// the four results and is registered together with res_valid.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int DATA_W     = CONV_DATA_W,
  parameter int FIRST_CAP  = CONV_FIRST_CAP,
  parameter int CAP_STRIDE = CONV_CAP_STRIDE,
  parameter int CNT_W      = CONV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c21,
  output logic [DATA_W-1:0] c22,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              overrun
`ifdef CONV_MAXPOOL_EN
  ,
  output logic [DATA_W-1:0] pool_out
`endif
);

  conv_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        idx_reg, idx_next;
  logic              overrun_reg, overrun_next;
  logic              busy_reg;
  logic              res_valid_reg;
  logic              cap_en;
  logic [CNT_W-1:0]  cap_target;
  logic [DATA_W-1:0] res_reg  [CONV_NUM_RES];
  logic [DATA_W-1:0] res_next [CONV_NUM_RES];

  // The counter value at which the result selected by idx is final on din.
  assign cap_target = CNT_W'(FIRST_CAP) + CNT_W'(CAP_STRIDE) * CNT_W'(idx_reg);

  // Next-state logic. clr overrides everything, including start and the handshake.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    overrun_next = overrun_reg;
    cap_en       = 1'b0;
    if (clr) begin
      state_next   = IDLE;
      cnt_next     = '0;
      idx_next     = '0;
      overrun_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = RUN;
            cnt_next   = CNT_W'(1);
            idx_next   = '0;
          end
        end
        RUN: begin
          if (start) overrun_next = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == cap_target) begin
            cap_en   = 1'b1;
            idx_next = idx_reg + 2'd1;
            if (idx_reg == 2'd3) state_next = HOLD;
          end
          // Only reachable if the parameters do not fit the counter width.
          if (cnt_reg == '1) state_next = HOLD;
        end
        HOLD: begin
          if (start) overrun_next = 1'b1;
          if (res_valid_reg && res_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control registers. busy and res_valid are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      overrun_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      overrun_reg   <= overrun_next;
      busy_reg      <= (state_next == RUN);
      res_valid_reg <= (state_next == HOLD);
    end
  end

  // Each result slot loads din unchanged when its capture point is reached.
  generate
    for (genvar gi = 0; gi < CONV_NUM_RES; gi++) begin : g_res
      assign res_next[gi] = (cap_en && (idx_reg == 2'(gi))) ? din : res_reg[gi];
    end
  endgenerate

  // Result registers. Only reset clears them; clr and the handshake leave them intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CONV_NUM_RES; i++) res_reg[i] <= '0;
    end else begin
      for (int i = 0; i < CONV_NUM_RES; i++) res_reg[i] <= res_next[i];
    end
  end

`ifdef CONV_MAXPOOL_EN
  logic [DATA_W-1:0] max_next;
  logic [DATA_W-1:0] pool_reg;

  // Max over the post-capture values, so C22 is included on the edge that enters HOLD.
  conv_max4 #(
    .W (DATA_W)
  ) u_max4 (
    .a (res_next[0]),
    .b (res_next[1]),
    .c (res_next[2]),
    .d (res_next[3]),
    .y (max_next)
  );

  // Latch the pooled value on the edge that enters HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool_reg <= '0;
    end else if ((state_reg == RUN) && (state_next == HOLD)) begin
      pool_reg <= max_next;
    end
  end

  assign pool_out = pool_reg;
`endif

  assign busy      = busy_reg;
  assign res_valid = res_valid_reg;
  assign overrun   = overrun_reg;
  assign c11       = res_reg[0];
  assign c12       = res_reg[1];
  assign c21       = res_reg[2];
  assign c22       = res_reg[3];

endmodule
